// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing for the VGA display path. DrawX/DrawY come straight from the
// pixel/line counters. Every other output is registered from the counters'
// next values, so all outputs describe the same pixel on every cycle with
// no decode logic between the flops and the ports.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        vblank,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // The counters are 10 bits wide; larger rasters cannot be represented.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode thresholds are 11 bits: a sync end can land exactly on 1024.
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [9:0]  hc_nxt;
    logic [9:0]  vc_nxt;
    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] hx_nxt;
    logic [10:0] vy_nxt;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        blank_nxt;
    logic        vblank_nxt;
    logic        tick_nxt;

    // Next raster position: pixel counter wraps each line, line counter
    // advances (and wraps) only on the pixel counter's wrap edge.
    always_comb begin
        h_wrap = (hc == H_LAST);
        v_wrap = (vc == V_LAST);
        hc_nxt = h_wrap ? 10'd0 : hc + 10'd1;
        vc_nxt = vc;
        if (h_wrap) begin
            vc_nxt = v_wrap ? 10'd0 : vc + 10'd1;
        end
    end

    // Output decodes evaluated on the position the counters move to next.
    always_comb begin
        hx_nxt     = {1'b0, hc_nxt};
        vy_nxt     = {1'b0, vc_nxt};
        hs_nxt     = !((hx_nxt >= HS_START) && (hx_nxt < HS_END));
        vs_nxt     = !((vy_nxt >= VS_START) && (vy_nxt < VS_END));
        blank_nxt  = (hx_nxt < H_VIS_END) && (vy_nxt < V_VIS_END);
        vblank_nxt = (vy_nxt >= V_VIS_END);
        tick_nxt   = (hc_nxt == 10'd0) && (vy_nxt == V_VIS_END);
    end

    // Pixel and line counters.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc <= 10'd0;
            vc <= 10'd0;
        end else begin
            hc <= hc_nxt;
            vc <= vc_nxt;
        end
    end

    // Registered sync/blanking flags; reset values describe pixel (0,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs         <= 1'b1;
            vs         <= 1'b1;
            blank      <= 1'b1;
            vblank     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            hs         <= hs_nxt;
            vs         <= vs_nxt;
            blank      <= blank_nxt;
            vblank     <= vblank_nxt;
            frame_tick <= tick_nxt;
        end
    end

    // Frame counter steps on the same edge frame_tick rises; wraps at 16 bits.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= 16'd0;
        end else if (tick_nxt) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default raster, small raster,
// tiny raster for the 16-bit frame counter wrap). A position-arithmetic model
// predicts every output from the number of edges since reset release.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        vblank;
        logic        tick;
        logic [15:0] fc;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic clk_a = 1'b0, clk_b = 1'b0, clk_c = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    longint n_a = 0, n_b = 0, n_c = 0;
    int blank_cnt_b = 0;

    logic [9:0]  x_a, y_a, x_b, y_b, x_c, y_c;
    logic        blank_a, hs_a, vs_a, vblank_a, tick_a;
    logic        blank_b, hs_b, vs_b, vblank_b, tick_b;
    logic        blank_c, hs_c, vs_c, vblank_c, tick_c;
    logic [15:0] fc_a, fc_b, fc_c;

    vga_timing_gen u_def (
        .vga_clk(clk_a), .reset_n(rst_a), .DrawX(x_a), .DrawY(y_a),
        .blank(blank_a), .hs(hs_a), .vs(vs_a), .vblank(vblank_a),
        .frame_tick(tick_a), .frame_count(fc_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_sml (
        .vga_clk(clk_b), .reset_n(rst_b), .DrawX(x_b), .DrawY(y_b),
        .blank(blank_b), .hs(hs_b), .vs(vs_b), .vblank(vblank_b),
        .frame_tick(tick_b), .frame_count(fc_b)
    );

    vga_timing_gen #(
        .H_VISIBLE(2), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_tny (
        .vga_clk(clk_c), .reset_n(rst_c), .DrawX(x_c), .DrawY(y_c),
        .blank(blank_c), .hs(hs_c), .vs(vs_c), .vblank(vblank_c),
        .frame_tick(tick_c), .frame_count(fc_c)
    );

    initial forever #5 clk_a = en_a & ~clk_a;
    initial forever #5 clk_b = en_b & ~clk_b;
    initial forever #2 clk_c = en_c & ~clk_c;

    // Edge index since reset release; the position follows from it directly.
    initial forever begin
        @(posedge clk_a or negedge rst_a);
        if (!rst_a) n_a = 0; else n_a++;
    end
    initial forever begin
        @(posedge clk_b or negedge rst_b);
        if (!rst_b) n_b = 0; else n_b++;
    end
    initial forever begin
        @(posedge clk_c or negedge rst_c);
        if (!rst_c) n_c = 0; else n_c++;
    end

    function automatic exp_t model_at(input longint hv, input longint hf, input longint hsw,
                                      input longint hb, input longint vv, input longint vf,
                                      input longint vsw, input longint vb, input longint n);
        longint ht, vt, pix, px, py, frames;
        exp_t e;
        ht       = hv + hf + hsw + hb;
        vt       = vv + vf + vsw + vb;
        pix      = n % (ht * vt);
        px       = pix % ht;
        py       = pix / ht;
        e.x      = 10'(px);
        e.y      = 10'(py);
        e.blank  = (px < hv) && (py < vv);
        e.hs     = !((px >= hv + hf) && (px < hv + hf + hsw));
        e.vs     = !((py >= vv + vf) && (py < vv + vf + vsw));
        e.vblank = (py >= vv);
        e.tick   = (px == 0) && (py == vv);
        frames   = (n >= vv * ht) ? ((n - vv * ht) / (ht * vt) + 1) : 0;
        e.fc     = 16'(frames);
        return e;
    endfunction

    task automatic cmp_cycle(input string tag, input longint n, input exp_t g, input exp_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s edge=%0d got x=%0d y=%0d blank=%b hs=%b vs=%b vblank=%b tick=%b fc=%h required x=%0d y=%0d blank=%b hs=%b vs=%b vblank=%b tick=%b fc=%h",
                     tag, n, g.x, g.y, g.blank, g.hs, g.vs, g.vblank, g.tick, g.fc,
                     e.x, e.y, e.blank, e.hs, e.vs, e.vblank, e.tick, e.fc);
        end
    endtask

    task automatic chk(input string name, input longint got, input longint req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial forever begin
        @(negedge clk_a);
        if (rst_a)
            cmp_cycle("def_cycle", n_a,
                      {x_a, y_a, blank_a, hs_a, vs_a, vblank_a, tick_a, fc_a},
                      model_at(640, 16, 96, 48, 480, 10, 2, 33, n_a));
    end
    initial forever begin
        @(negedge clk_b);
        if (rst_b) begin
            cmp_cycle("sml_cycle", n_b,
                      {x_b, y_b, blank_b, hs_b, vs_b, vblank_b, tick_b, fc_b},
                      model_at(4, 1, 2, 1, 3, 1, 1, 1, n_b));
            if (n_b >= 48 && n_b < 96 && blank_b) blank_cnt_b++;
        end
    end
    initial forever begin
        @(negedge clk_c);
        if (rst_c)
            cmp_cycle("tny_cycle", n_c,
                      {x_c, y_c, blank_c, hs_c, vs_c, vblank_c, tick_c, fc_c},
                      model_at(2, 1, 1, 1, 2, 1, 1, 1, n_c));
    end

    task automatic run_a(input longint k);
        while (n_a < k) begin @(posedge clk_a); #1; end
    endtask
    task automatic run_b(input longint k);
        while (n_b < k) begin @(posedge clk_b); #1; end
    endtask
    task automatic run_c(input longint k);
        while (n_c < k) begin @(posedge clk_c); #1; end
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- default raster: line timing and asynchronous reset ----
        en_a = 1'b1;
        repeat (3) @(posedge clk_a);
        #2 rst_a = 1'b1;
        run_a(1);    chk("first_edge_x", x_a, 1);   chk("first_edge_y", y_a, 0);
        run_a(639);  chk("blank_639", blank_a, 1);
        run_a(640);  chk("blank_640", blank_a, 0);  chk("x_640", x_a, 640);
        run_a(655);  chk("hs_655", hs_a, 1);
        run_a(656);  chk("hs_656", hs_a, 0);        chk("x_656", x_a, 656);
        run_a(751);  chk("hs_751", hs_a, 0);
        run_a(752);  chk("hs_752", hs_a, 1);
        run_a(800);  chk("wrap_x", x_a, 0);         chk("wrap_y", y_a, 1);
        chk("wrap_blank", blank_a, 1);
        run_a(2700); chk("mid_x", x_a, 300);        chk("mid_y", y_a, 3);
        rst_a = 1'b0;
        #1;
        chk("rst_x", x_a, 0);          chk("rst_y", y_a, 0);
        chk("rst_hs", hs_a, 1);        chk("rst_vs", vs_a, 1);
        chk("rst_blank", blank_a, 1);  chk("rst_vblank", vblank_a, 0);
        chk("rst_tick", tick_a, 0);    chk("rst_fc", fc_a, 0);
        en_a = 1'b0;

        // ---- small raster: vertical timing, frame tick, frame wrap ----
        en_b = 1'b1;
        repeat (2) @(posedge clk_b);
        #2 rst_b = 1'b1;
        run_b(23);  chk("s23_tick", tick_b, 0);  chk("s23_fc", fc_b, 0);  chk("s23_vblank", vblank_b, 0);
        run_b(24);  chk("s24_tick", tick_b, 1);  chk("s24_fc", fc_b, 1);  chk("s24_vblank", vblank_b, 1);
        chk("s24_blank", blank_b, 0);  chk("s24_y", y_b, 3);  chk("s24_x", x_b, 0);
        run_b(25);  chk("s25_tick", tick_b, 0);  chk("s25_fc", fc_b, 1);
        run_b(28);  chk("s28_hs", hs_b, 1);
        run_b(29);  chk("s29_hs", hs_b, 0);
        run_b(30);  chk("s30_hs", hs_b, 0);
        run_b(31);  chk("s31_hs", hs_b, 1);
        run_b(32);  chk("s32_vs", vs_b, 0);
        run_b(39);  chk("s39_vs", vs_b, 0);
        run_b(40);  chk("s40_vs", vs_b, 1);
        run_b(47);  chk("s47_vblank", vblank_b, 1);  chk("s47_blank", blank_b, 0);
        run_b(48);  chk("s48_vblank", vblank_b, 0);  chk("s48_blank", blank_b, 1);
        chk("s48_x", x_b, 0);  chk("s48_y", y_b, 0);  chk("s48_vs", vs_b, 1);  chk("s48_fc", fc_b, 1);
        run_b(72);  chk("s72_tick", tick_b, 1);  chk("s72_fc", fc_b, 2);
        run_b(96);  chk("s_blank_per_frame", blank_cnt_b, 12);
        run_b(116); chk("s116_x", x_b, 4);       chk("s116_y", y_b, 2);
        rst_b = 1'b0;
        #1;
        chk("s_rst_fc", fc_b, 0);  chk("s_rst_tick", tick_b, 0);  chk("s_rst_x", x_b, 0);
        @(posedge clk_b);
        #2 rst_b = 1'b1;
        run_b(23);  chk("s_re23_fc", fc_b, 0);   chk("s_re23_tick", tick_b, 0);
        run_b(24);  chk("s_re24_fc", fc_b, 1);   chk("s_re24_tick", tick_b, 1);
        en_b = 1'b0;

        // ---- tiny raster: 65536 frames to wrap frame_count ----
        en_c = 1'b1;
        repeat (2) @(posedge clk_c);
        #1 rst_c = 1'b1;
        run_c(10);       chk("t10_tick", tick_c, 1);  chk("t10_fc", fc_c, 1);
        run_c(35);       chk("t35_tick", tick_c, 1);  chk("t35_fc", fc_c, 2);
        run_c(1638360);  chk("t_ffff_tick", tick_c, 1);  chk("t_ffff_fc", fc_c, 16'hFFFF);
        run_c(1638361);  chk("t_ffff_hold_tick", tick_c, 0);  chk("t_ffff_hold_fc", fc_c, 16'hFFFF);
        run_c(1638385);  chk("t_wrap_tick", tick_c, 1);  chk("t_wrap_fc", fc_c, 0);
        run_c(1638386);  chk("t_wrap_hold_fc", fc_c, 0);
        en_c = 1'b0;

        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the VGA display path. It produces the pixel coordinates (DrawX, DrawY), the active-high visible-region flag (blank), and the active-low hs and vs sync pulses. Every sprite and background renderer on vga_clk consumes these outputs. It also gives game logic a one-cycle frame_tick at the start of vertical blanking and a free-running frame counter, so game state can be updated while nothing is drawn.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- vga_clk  input  1  pixel clock; all state updates on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- DrawX  output  10  current horizontal count, 0..H_TOTAL-1
- DrawY  output  10  current vertical count, 0..V_TOTAL-1
- blank  output  1  1 = visible pixel (DrawX < H_VISIBLE and DrawY < V_VISIBLE), 0 = blanking
- hs  output  1  horizontal sync, active low
- vs  output  1  vertical sync, active low
- vblank  output  1  1 while DrawY >= V_VISIBLE
- frame_tick  output  1  one-cycle pulse at (DrawX, DrawY) = (0, V_VISIBLE)
- frame_count  output  16  frames completed since reset, wraps

## Operation
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800)
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 525)
  - Both must be <= 1024. The block checks this at elaboration.
- Horizontal counter hc:
  - Increments each clock.
  - At H_TOTAL-1 it wraps to 0 and the vertical counter vc advances.
- Vertical counter vc:
  - Wraps from V_TOTAL-1 to 0 on the same edge that hc wraps.
- DrawX = hc and DrawY = vc, straight from the counter flops.
- All other outputs are flops loaded from the *next* counter values, so every output describes the same pixel as DrawX/DrawY on every cycle, with no combinational decode at the ports.
- Output decodes:
  - hs = 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (default 656..751)
  - vs = 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (default 490..491)
  - blank and vblank per the Interface definitions
- frame_tick:
  - High for exactly the one cycle in which (DrawX, DrawY) = (0, V_VISIBLE).
  - frame_count increments on the same edge that frame_tick rises; 16-bit wrap, 0xFFFF -> 0x0000.
- Reset behaviour:
  - reset_n low clears state immediately, independent of vga_clk.
  - Reset values: hc=0, vc=0, hs=1, vs=1, blank=1, vblank=0, frame_tick=0, frame_count=0. These match pixel (0,0).
  - Reset asserted mid-frame abandons the frame. frame_count does not increment and no frame_tick is issued.
- No enable or stall input; the counters run continuously out of reset.

## Timing
- First rising edge after reset_n deasserts moves to (1,0).
- Pixel (x,y) appears at cycle y*H_TOTAL + x after release (edges counted from 0).
- Latency from counter value to every decoded output is 0 cycles; all outputs change on the same edge.
- Downstream renderers read ROM on the falling edge and register RGB on the rising edge. The RGB they drive is one clock behind DrawX, which is their responsibility.
- Line wrap (hc 799 -> 0) and frame wrap (vc 524 -> 0) occur on the same edge. At (799,524) -> (0,0): vblank falls, blank rises, vs is unaffected.
- Frame period at defaults is 420000 clocks.

## Test plan
- Reset: hold reset_n low mid-frame at (300,200) without clocking -> immediately DrawX=0, DrawY=0, hs=1, vs=1, blank=1, vblank=0, frame_tick=0, frame_count=0.
- hsync: after release, hs falls on edge 656 (DrawX=656), rises on edge 752; blank falls at DrawX=640; line 0 wraps to DrawX=0, DrawY=1 on edge 800.
- vsync: vs low exactly for DrawY 490..491 (1600 clocks); vblank high for DrawY 480..524; blank never high while vblank=1.
- Frame tick: one pulse at edge 384000 (DrawY=480, DrawX=0), frame_count 0 -> 1; next pulse 420000 clocks later; blank=1 for 307200 clocks per frame.
- Wrap: force frame_count to 0xFFFF via 65535 frames with small parameters (all 2/1/1/1) -> next tick gives 0x0000.
- Small configuration H_VISIBLE=4, H_FRONT=1, H_SYNC=2, H_BACK=1, V_VISIBLE=3, V_FRONT=1, V_SYNC=1, V_BACK=1 -> H_TOTAL=8, V_TOTAL=6, hs low at DrawX 5..6, vs low at DrawY 4, frame period 48 clocks.
